// File: rtl/serial_tx.sv
`timescale 1ns/1ps
// serial_tx: 8N1 UART transmitter fed by a FIFO_DEPTH-entry byte FIFO; each bit lasts WAITCNT clocks, LSB first.
// Latency: a byte pushed into an empty, idle block pulls TXD low one edge later. Backpressure: FULL; a WE while FULL drops the byte and sets sticky OVF.
// Optional macro SERIAL_TX_PARITY_EN adds an even-parity bit after D7 (11*WAITCNT clocks per frame).
module serial_tx #(
  parameter int WAITCNT    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic [7:0] DATA,
  input  logic       WE,
  output logic       FULL,
  output logic       BUSY,
  output logic       OVF,
  output logic       TXD
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(WAITCNT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAITCNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          push, pop, load, fifo_empty;
  logic [7:0]    head;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          txd_n;
  logic          bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic          par, par_n;
`endif

  assign push       = WE && !FULL;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign bit_end    = (cnt == CNT_MAX);

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + 1'b1;
    else if (!push && pop)
      count_n = count - 1'b1;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    txd_n     = TXD;
    load      = 1'b0;
    pop       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_n     = par;
`endif
    if (state == ST_IDLE) begin
      txd_n = 1'b1;
      load  = !fifo_empty;
    end else if (!bit_end) begin
      cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = CNT_ONE;
      case (state)
        ST_START: begin
          state_n   = ST_DATA;
          txd_n     = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = '0;
        end
        ST_DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_n = ST_PARITY;
            txd_n   = par;
`else
            state_n = ST_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            txd_n     = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
            bit_idx_n = bit_idx + 1'b1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end
`endif
        ST_STOP: begin
          // Pop straight into START so back-to-back frames carry no idle clock.
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
            txd_n   = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if (load) begin
      pop     = 1'b1;
      shreg_n = head;
      txd_n   = 1'b0;
      cnt_n   = CNT_ONE;
      state_n = ST_START;
`ifdef SERIAL_TX_PARITY_EN
      par_n   = ^head;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      TXD     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      TXD     <= txd_n;
`ifdef SERIAL_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      FULL   <= 1'b0;
      BUSY   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      FULL  <= (count_n == DEPTH_C);
      BUSY  <= !((state_n == ST_IDLE) && (count_n == '0));
      // FULL is the pre-edge occupancy, so a pop on this edge does not rescue the byte.
      if (WE && FULL) OVF <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DATA;
  end

endmodule

// File: tb/tb_serial_tx.sv
`timescale 1ns/1ps
// Bench for serial_tx: randomized pushes checked against a frame-level model; a monitor decodes TXD frames against a scoreboard queue.
module tb_serial_tx;
  localparam int W     = 5;
  localparam int DEPTH = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * W;

  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic       WE = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       FULL, BUSY, OVF, TXD;

  serial_tx #(.WAITCNT(W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_X(RST_X), .DATA(DATA), .WE(WE),
    .FULL(FULL), .BUSY(BUSY), .OVF(OVF), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int epoch = 0;

  typedef struct {
    logic [7:0] b;
    int         s;
  } exp_t;
  exp_t exp_q[$];

  // Model: a byte queue plus the start edge of the frame currently on the line.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic m_txd(input int t);
    int k;
    if (!m_active) return 1'b1;
    k = (t - m_start) / W;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
`ifdef SERIAL_TX_PARITY_EN
    if (k == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  task automatic model_step(input int t, input bit we, input logic [7:0] d);
    bit   ne, fb;
    exp_t e;
    ne = (mq.size() > 0);
    fb = (mq.size() == DEPTH);
    if (m_active && (t == m_start + FRAME)) m_active = 1'b0;
    if (ne && !m_active) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_start  = t;
      e.b = m_byte;
      e.s = t;
      exp_q.push_back(e);
    end
    if (we) begin
      if (fb) m_ovf = 1'b1;
      else    mq.push_back(d);
    end
  endtask

  task automatic check_outs();
    chk("TXD",  {31'd0, TXD},  {31'd0, m_txd(cyc)});
    chk("FULL", {31'd0, FULL}, {31'd0, mq.size() == DEPTH});
    chk("BUSY", {31'd0, BUSY}, {31'd0, (m_active || mq.size() > 0)});
    chk("OVF",  {31'd0, OVF},  {31'd0, m_ovf});
  endtask

  task automatic cycle(input bit we, input logic [7:0] d);
    WE   = we;
    DATA = d;
    model_step(cyc + 1, we, d);
    @(negedge CLK);
    WE = 1'b0;
    check_outs();
  endtask

  task automatic do_reset();
    #2;
    RST_X = 1'b0;
    #1;
    chk("rst_async_TXD",  {31'd0, TXD},  32'd1);
    chk("rst_async_BUSY", {31'd0, BUSY}, 32'd0);
    chk("rst_async_FULL", {31'd0, FULL}, 32'd0);
    chk("rst_async_OVF",  {31'd0, OVF},  32'd0);
    mq.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    epoch++;
    repeat (2) begin
      @(negedge CLK);
      check_outs();
    end
    RST_X = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    while ((m_active || mq.size() > 0) && g < 5000) begin
      cycle(1'b0, 8'h00);
      g++;
    end
    repeat (5) cycle(1'b0, 8'h00);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  task automatic decode();
    int         s, ep;
    logic [NB-1:0] bits;
    exp_t       e;
    s  = cyc;
    ep = epoch;
    repeat (W/2) @(negedge CLK);
    bits[0] = TXD;
    for (int k = 1; k < NB; k++) begin
      repeat (W) @(negedge CLK);
      bits[k] = TXD;
    end
    if (ep == epoch) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame at cyc %0d: got frame %0h expected none", s, bits);
      end else begin
        e = exp_q.pop_front();
        chk("frame_start_cyc", s, e.s);
        chk("start_bit", {31'd0, bits[0]}, 32'd0);
        chk("data_byte", {24'd0, bits[8:1]}, {24'd0, e.b});
`ifdef SERIAL_TX_PARITY_EN
        chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^e.b});
`endif
        chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
      end
    end
  endtask

  logic mon_prev = 1'b1;
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_X && mon_prev && !TXD) decode();
      mon_prev = TXD;
    end
  end

  initial begin
    int g;
    int rate;
    RST_X = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check_outs();
    end
    RST_X = 1'b1;

    cycle(1'b1, 8'hA5);
    drain();

    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'h55);
    drain();

    cycle(1'b1, 8'h07);
    drain();
    cycle(1'b1, 8'h03);
    drain();

    // Reset while D0 (a zero) is on the line.
    cycle(1'b1, 8'h3C);
    cycle(1'b1, 8'hC3);
    repeat (7) cycle(1'b0, 8'h00);
    chk("txd_low_before_reset", {31'd0, TXD}, 32'd0);
    do_reset();
    repeat (60) cycle(1'b0, 8'h00);

    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h10 + 8'(i));
    chk("ovf_after_burst", {31'd0, OVF}, 32'd1);
    drain();
    chk("ovf_sticky", {31'd0, OVF}, 32'd1);
    do_reset();

    // Fill the FIFO, then write on the exact STOP->START pop edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i));
    g = 0;
    while ((cyc + 1 != m_start + FRAME) && g < 200) begin
      cycle(1'b0, 8'h00);
      g++;
    end
    chk("full_before_pop_edge", {31'd0, FULL}, 32'd1);
    chk("ovf_clear_before_pop_edge", {31'd0, OVF}, 32'd0);
    cycle(1'b1, 8'hEE);
    chk("ovf_on_pop_edge", {31'd0, OVF}, 32'd1);
    chk("full_after_pop_edge", {31'd0, FULL}, 32'd0);
    drain();
    do_reset();

    rate = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) rate = ($urandom_range(0, 2) == 0) ? 40 : $urandom_range(1, 4);
      cycle($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
